// File: rtl/tetris_line_clear.sv
// Line-clear engine: scans the playfield bottom-up, drops full rows, compacts the
// remaining rows downward and zero-fills the top, keeping a saturating line total.
module tetris_line_clear #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] board_out,
    output logic [4:0]           lines_cleared,
    output logic [9:0]           total_lines
);

    localparam int AW = $clog2(ROWS);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

    state_t                 state, state_d;
    logic [COLS-1:0]        work   [ROWS];
    logic [COLS-1:0]        work_d [ROWS];
    logic signed [PW-1:0]   rd, rd_d, wr, wr_d;
    logic [4:0]             n, n_d;
    logic                   row_full;
    logic [ROWS*COLS-1:0]   work_flat;
    logic [10:0]            total_sum;
    logic                   finishing;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state;
        rd_d     = rd;
        wr_d     = wr;
        n_d      = n;
        work_d   = work;
        row_full = &work[rd[AW-1:0]];
        case (state)
            IDLE: begin
                if (start) begin
                    for (int r = 0; r < ROWS; r++) work_d[r] = board_in[COLS*r +: COLS];
                    rd_d    = PW'(ROWS - 1);
                    wr_d    = PW'(ROWS - 1);
                    n_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // wr never drops below rd, so the in-place copy only overwrites rows already read.
                if (row_full) begin
                    n_d = n + 5'd1;
                end else begin
                    work_d[wr[AW-1:0]] = work[rd[AW-1:0]];
                    wr_d = wr - PW'(1);
                end
                rd_d = rd - PW'(1);
                if (rd == '0) state_d = (n_d == '0) ? DONE : FILL;
            end
            FILL: begin
                work_d[wr[AW-1:0]] = '0;
                wr_d = wr - PW'(1);
                if (wr == '0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_flat = '0;
        for (int r = 0; r < ROWS; r++) work_flat[COLS*r +: COLS] = work_d[r];
    end

    // Results are loaded on the edge entering DONE so they are valid alongside done.
    assign finishing = (state == SCAN || state == FILL) && state_d == DONE;
    assign total_sum = {1'b0, total_lines} + {6'b0, n_d};

    // NOTE: the working board is reset too, since an aborted pass must leave nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rd            <= '0;
            wr            <= '0;
            n             <= '0;
            work          <= '{default: '0};
            board_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            state <= state_d;
            rd    <= rd_d;
            wr    <= wr_d;
            n     <= n_d;
            work  <= work_d;
            if (finishing) begin
                board_out     <= work_flat;
                lines_cleared <= n_d;
                total_lines   <= (total_sum > 11'd1023) ? 10'h3FF : total_sum[9:0];
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tetris_line_clear.sv
// Randomized scoreboard bench for tetris_line_clear: driver pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_tetris_line_clear;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int W    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] board_in;
    logic         busy;
    logic         done;
    logic [W-1:0] board_out;
    logic [4:0]   lines_cleared;
    logic [9:0]   total_lines;

    tetris_line_clear #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .board_in      (board_in),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] board;
        int           n;
        int           total;
        longint       due;
    } exp_t;

    exp_t         sb[$];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;
    int           done_cnt = 0;
    int           push_cnt = 0;
    int           busy_cnt = 0;
    int           model_total = 0;
    longint       cyc = 0;
    logic [W-1:0] prev_board;
    logic [4:0]   prev_lines;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: collect non-full rows bottom-up and restack them from the floor.
    function automatic void model(input logic [W-1:0] b, output logic [W-1:0] o, output int n);
        logic [COLS-1:0] kept[$];
        logic [COLS-1:0] row;
        n = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = b[COLS*r +: COLS];
            if (row == {COLS{1'b1}}) n++;
            else kept.push_back(row);
        end
        o = '0;
        for (int i = 0; i < kept.size(); i++) o[COLS*(ROWS-1-i) +: COLS] = kept[i];
    endfunction

    function automatic logic [W-1:0] set_row(input logic [W-1:0] b, input int r, input logic [COLS-1:0] v);
        logic [W-1:0] t;
        t = b;
        t[COLS*r +: COLS] = v;
        return t;
    endfunction

    function automatic logic [W-1:0] rand_board(input int full_pct);
        logic [W-1:0] b;
        b = '0;
        for (int r = 0; r < ROWS; r++)
            b[COLS*r +: COLS] = ($urandom_range(0, 99) < full_pct) ? {COLS{1'b1}} : COLS'($urandom);
        return b;
    endfunction

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle timeout", 1'b0, W'(busy), W'(0));
    endtask

    task automatic run_pass(input logic [W-1:0] b);
        exp_t e;
        int   n;
        wait_idle();
        model(b, e.board, n);
        model_total = (model_total + n > 1023) ? 1023 : model_total + n;
        e.n     = n;
        e.total = model_total;
        e.due   = cyc + ROWS + n + 1;
        sb.push_back(e);
        push_cnt++;
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            else busy_cnt = 0;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected done", 1'b0, W'(1), W'(0));
                end else begin
                    e = sb.pop_front();
                    check("board_out", board_out == e.board, board_out, e.board);
                    check("lines_cleared", lines_cleared == 5'(e.n), W'(lines_cleared), W'(e.n));
                    check("total_lines", total_lines == 10'(e.total), W'(total_lines), W'(e.total));
                    check("done latency", cyc == e.due, W'(cyc), W'(e.due));
                    check("busy length", busy_cnt == ROWS + e.n + 1, W'(busy_cnt), W'(ROWS + e.n + 1));
                end
            end else begin
                check("board_out stable", board_out == prev_board, board_out, prev_board);
                check("lines stable", lines_cleared == prev_lines, W'(lines_cleared), W'(prev_lines));
            end
        end
        prev_board = board_out;
        prev_lines = lines_cleared;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b;
        int           k;
        rst      = 1'b1;
        start    = 1'b0;
        board_in = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy == 1'b0, W'(busy), W'(0));
        check("reset done", done == 1'b0, W'(done), W'(0));
        check("reset board_out", board_out == '0, board_out, W'(0));
        check("reset lines", lines_cleared == '0, W'(lines_cleared), W'(0));
        check("reset total", total_lines == '0, W'(total_lines), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed boards: empty, one clear, four clears, interleaved clears.
        run_pass('0);
        b = set_row(set_row('0, 19, 10'h3FF), 18, 10'h0A3);
        run_pass(b);
        b = '0;
        for (int r = 16; r < 20; r++) b = set_row(b, r, 10'h3FF);
        b = set_row(b, 15, 10'h001);
        run_pass(b);
        b = set_row(set_row(set_row(set_row('0, 19, 10'h3FF), 18, 10'h0F0), 17, 10'h3FF), 16, 10'h00F);
        run_pass(b);

        // Start pulsed during SCAN must be ignored.
        run_pass(rand_board(40));
        repeat (3) @(negedge clk);
        board_in = rand_board(50);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("single done", done_cnt == push_cnt, W'(done_cnt), W'(push_cnt));

        // Reset in the middle of a pass aborts it.
        run_pass(rand_board(40));
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy == 1'b0, W'(busy), W'(0));
        check("abort done", done == 1'b0, W'(done), W'(0));
        check("abort board_out", board_out == '0, board_out, W'(0));
        check("abort total", total_lines == '0, W'(total_lines), W'(0));
        sb.delete();
        push_cnt    = done_cnt;
        model_total = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Random boards, then full boards driving total_lines into saturation.
        for (int i = 0; i < 40; i++) run_pass(rand_board(($urandom_range(0, 3) == 0) ? 90 : 35));
        for (int i = 0; i < 52; i++) run_pass({W{1'b1}});

        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard drained", sb.size() == 0, W'(sb.size()), W'(0));
        check("done count", done_cnt == push_cnt, W'(done_cnt), W'(push_cnt));
        check("final total", total_lines == 10'd1023, W'(total_lines), W'(1023));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
